// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared cpu datapath constants
// Default register-file geometry and the decoder's read-port roles.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int RF_NUM_RD  = 3;

  // Read-port roles as wired by the decoder.
  localparam int RD_SRC = 0;
  localparam int RD_TMP = 1;
  localparam int RD_DST = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits for pending writes
// A new producer (set) outranks a retiring one (clear) on the same register.
module rf_scoreboard #(
  parameter int ADDR_W  = 4,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sb_set,
  input  logic [ADDR_W-1:0]    sb_addr,
  input  logic                 clr_en,
  input  logic [ADDR_W-1:0]    clr_addr,
  output logic [2**ADDR_W-1:0] busy_vec
);
  import cpu_pkg::*;

  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_next;

  always_comb begin
    busy_next = busy_q;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (sb_set) busy_next[sb_addr] = 1'b1;
    if (ZERO_R0) busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_next;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised multi-port register file
// Combinational reads with optional write bypass, hardwired R0 and busy scoreboard.
module reg_file_mp #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::REG_ADDR_W,
  parameter int NUM_RD  = cpu_pkg::RF_NUM_RD,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);
  import cpu_pkg::*;

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_commit;

  assign wr_commit = wr_en && !(ZERO_R0 && (wr_addr == '0));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int n = 0; n < NUM_REGS; n++) regs[n] <= '0;
    end else if (wr_commit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .busy_vec (busy_vec)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              fwd;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr    = rd_addr[g*ADDR_W +: ADDR_W];
    assign is_zero = ZERO_R0 && (addr == '0);
    assign fwd     = BYPASS && wr_en && (wr_addr == addr);

    // A retiring write frees the register this cycle unless a new producer claims it.
    always_comb begin
      data = regs[addr];
      busy = busy_vec[addr];
      if (is_zero) begin
        data = '0;
        busy = 1'b0;
      end else if (fwd) begin
        data = wr_data;
        busy = sb_set && (sb_addr == addr);
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = data;
    assign rd_busy[g]                  = busy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp
// Default instance (bypass, R0) and a 4-port/32-reg/16-bit instance without bypass or R0.
module tb_reg_file_mp;

  logic clk;
  logic rst;

  logic [11:0] a_rd_addr;
  logic [95:0] a_rd_data;
  logic [2:0]  a_rd_busy;
  logic        a_wr_en;
  logic [3:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_sb_set;
  logic [3:0]  a_sb_addr;
  logic [15:0] a_busy_vec;

  logic [19:0] b_rd_addr;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_busy;
  logic        b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic        b_sb_set;
  logic [4:0]  b_sb_addr;
  logic [31:0] b_busy_vec;

  logic [31:0] m_reg [16];
  logic [15:0] m_busy;
  logic [15:0] k_reg [32];
  logic [31:0] k_busy;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_mp dut_a (
    .sys_clk (clk), .sys_rst (rst),
    .rd_addr (a_rd_addr), .rd_data (a_rd_data), .rd_busy (a_rd_busy),
    .wr_en (a_wr_en), .wr_addr (a_wr_addr), .wr_data (a_wr_data),
    .sb_set (a_sb_set), .sb_addr (a_sb_addr), .busy_vec (a_busy_vec)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(5), .NUM_RD(4), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut_b (
    .sys_clk (clk), .sys_rst (rst),
    .rd_addr (b_rd_addr), .rd_data (b_rd_data), .rd_busy (b_rd_busy),
    .wr_en (b_wr_en), .wr_addr (b_wr_addr), .wr_data (b_wr_data),
    .sb_set (b_sb_set), .sb_addr (b_sb_addr), .busy_vec (b_busy_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] a_exp_data(int p);
    logic [3:0] ad;
    ad = a_rd_addr[p*4 +: 4];
    if (ad == 4'd0) return 32'h0;
    if (a_wr_en && a_wr_addr == ad) return a_wr_data;
    return m_reg[ad];
  endfunction

  function automatic logic a_exp_busy(int p);
    logic [3:0] ad;
    ad = a_rd_addr[p*4 +: 4];
    if (ad == 4'd0) return 1'b0;
    if (a_wr_en && a_wr_addr == ad) return a_sb_set && (a_sb_addr == ad);
    return m_busy[ad];
  endfunction

  function automatic logic [15:0] b_exp_data(int p);
    return k_reg[b_rd_addr[p*5 +: 5]];
  endfunction

  function automatic logic b_exp_busy(int p);
    return k_busy[b_rd_addr[p*5 +: 5]];
  endfunction

  task automatic commit();
    if (rst) begin
      for (int n = 0; n < 16; n++) m_reg[n] = 32'h0;
      for (int n = 0; n < 32; n++) k_reg[n] = 16'h0;
      m_busy = '0;
      k_busy = '0;
    end else begin
      if (a_wr_en) begin
        if (a_wr_addr != 4'd0) m_reg[a_wr_addr] = a_wr_data;
        m_busy[a_wr_addr] = 1'b0;
      end
      if (a_sb_set) m_busy[a_sb_addr] = 1'b1;
      m_busy[0] = 1'b0;
      if (b_wr_en) begin
        k_reg[b_wr_addr] = b_wr_data;
        k_busy[b_wr_addr] = 1'b0;
      end
      if (b_sb_set) k_busy[b_sb_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic idle();
    a_wr_en = 1'b0; a_sb_set = 1'b0;
    b_wr_en = 1'b0; b_sb_set = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_sb_addr = '0;
    b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_sb_addr = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++; if (a_rd_data !== 96'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", a_rd_data); end
    n_checks++; if (a_busy_vec !== 16'h0) begin n_fail++; $display("FAIL reset_busy_vec: got %h expected 0", a_busy_vec); end
    a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 32'hDEADBEEF;
    a_sb_set = 1'b1; a_sb_addr = 4'd6;
    tick();
    idle();
    a_rd_addr = {4'd6, 4'd0, 4'd5};
    #1;
    n_checks++; if (a_rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pre_reset_reg5: got %h expected deadbeef", a_rd_data[31:0]); end
    n_checks++; if (a_busy_vec !== 16'h0040) begin n_fail++; $display("FAIL pre_reset_busy: got %h expected 0040", a_busy_vec); end
    // Reset must win over a simultaneous write and scoreboard set.
    rst = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 32'h11111111;
    a_sb_set = 1'b1; a_sb_addr = 4'd6;
    tick();
    rst = 1'b0;
    idle();
    #1;
    n_checks++; if (a_rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL post_reset_reg5: got %h expected 0", a_rd_data[31:0]); end
    n_checks++; if (a_busy_vec !== 16'h0) begin n_fail++; $display("FAIL post_reset_busy_vec: got %h expected 0", a_busy_vec); end
    n_checks++; if (a_rd_busy !== 3'b000) begin n_fail++; $display("FAIL post_reset_rd_busy: got %b expected 000", a_rd_busy); end
  endtask

  task automatic test_bypass();
    a_rd_addr = {4'd0, 4'd3, 4'd0};
    a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 32'h12345678;
    b_rd_addr = {5'd0, 5'd0, 5'd3, 5'd0};
    b_wr_en = 1'b1; b_wr_addr = 5'd3; b_wr_data = 16'h5678;
    #1;
    n_checks++; if (a_rd_data[63:32] !== 32'h12345678) begin n_fail++; $display("FAIL bypass_same_cycle: got %h expected 12345678", a_rd_data[63:32]); end
    n_checks++; if (b_rd_data[31:16] !== 16'h0) begin n_fail++; $display("FAIL nobypass_same_cycle: got %h expected 0000", b_rd_data[31:16]); end
    tick();
    idle();
    #1;
    n_checks++; if (a_rd_data[63:32] !== 32'h12345678) begin n_fail++; $display("FAIL bypass_after_edge: got %h expected 12345678", a_rd_data[63:32]); end
    n_checks++; if (b_rd_data[31:16] !== 16'h5678) begin n_fail++; $display("FAIL nobypass_after_edge: got %h expected 5678", b_rd_data[31:16]); end
  endtask

  task automatic test_r0();
    a_rd_addr = 12'h000;
    a_wr_en = 1'b1; a_wr_addr = 4'd0; a_wr_data = 32'hFFFFFFFF;
    a_sb_set = 1'b1; a_sb_addr = 4'd0;
    #1;
    n_checks++; if (a_rd_data !== 96'h0) begin n_fail++; $display("FAIL r0_same_cycle: got %h expected 0", a_rd_data); end
    n_checks++; if (a_rd_busy !== 3'b000) begin n_fail++; $display("FAIL r0_rd_busy: got %b expected 000", a_rd_busy); end
    tick();
    idle();
    #1;
    n_checks++; if (a_rd_data !== 96'h0) begin n_fail++; $display("FAIL r0_after_edge: got %h expected 0", a_rd_data); end
    n_checks++; if (a_busy_vec[0] !== 1'b0) begin n_fail++; $display("FAIL r0_busy_bit: got %b expected 0", a_busy_vec[0]); end
  endtask

  task automatic test_scoreboard();
    a_sb_set = 1'b1; a_sb_addr = 4'd7;
    a_rd_addr = {4'd7, 4'd0, 4'd0};
    tick();
    idle();
    #1;
    n_checks++; if (a_rd_busy !== 3'b100) begin n_fail++; $display("FAIL sb_rd_busy_set: got %b expected 100", a_rd_busy); end
    n_checks++; if (a_busy_vec !== 16'h0080) begin n_fail++; $display("FAIL sb_busy_vec_set: got %h expected 0080", a_busy_vec); end
    a_wr_en = 1'b1; a_wr_addr = 4'd7; a_wr_data = 32'hA5A5A5A5;
    #1;
    n_checks++; if (a_rd_busy[2] !== 1'b0) begin n_fail++; $display("FAIL sb_retire_busy: got %b expected 0", a_rd_busy[2]); end
    n_checks++; if (a_rd_data[95:64] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_retire_data: got %h expected a5a5a5a5", a_rd_data[95:64]); end
    tick();
    idle();
    #1;
    n_checks++; if (a_busy_vec[7] !== 1'b0) begin n_fail++; $display("FAIL sb_cleared: got %b expected 0", a_busy_vec[7]); end
  endtask

  task automatic test_set_clear();
    a_sb_set = 1'b1; a_sb_addr = 4'd9;
    tick();
    tick();
    a_wr_en = 1'b1; a_wr_addr = 4'd9; a_wr_data = 32'h0BADF00D;
    a_rd_addr = {4'd0, 4'd0, 4'd9};
    #1;
    n_checks++; if (a_rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL setclr_rd_busy: got %b expected 1", a_rd_busy[0]); end
    tick();
    idle();
    #1;
    n_checks++; if (a_busy_vec[9] !== 1'b1) begin n_fail++; $display("FAIL setclr_busy_vec: got %b expected 1", a_busy_vec[9]); end
    n_checks++; if (a_rd_data[31:0] !== 32'h0BADF00D) begin n_fail++; $display("FAIL setclr_data: got %h expected 0badf00d", a_rd_data[31:0]); end
    a_wr_en = 1'b1; a_wr_addr = 4'd9; a_wr_data = 32'h00000009;
    tick();
    idle();
    #1;
    n_checks++; if (a_busy_vec[9] !== 1'b0) begin n_fail++; $display("FAIL single_producer_clear: got %b expected 0", a_busy_vec[9]); end
  endtask

  task automatic test_param();
    b_wr_en = 1'b1; b_wr_addr = 5'd31; b_wr_data = 16'hBEEF;
    tick();
    idle();
    b_rd_addr = {4{5'd31}};
    #1;
    n_checks++; if (b_rd_data !== {4{16'hBEEF}}) begin n_fail++; $display("FAIL param_all_ports: got %h expected beefbeefbeefbeef", b_rd_data); end
    b_sb_set = 1'b1; b_sb_addr = 5'd31;
    tick();
    idle();
    b_wr_en = 1'b1; b_wr_addr = 5'd31; b_wr_data = 16'h1234;
    #1;
    n_checks++; if (b_rd_busy !== 4'hF) begin n_fail++; $display("FAIL param_busy_no_bypass: got %b expected 1111", b_rd_busy); end
    n_checks++; if (b_busy_vec !== 32'h80000000) begin n_fail++; $display("FAIL param_busy_vec: got %h expected 80000000", b_busy_vec); end
    tick();
    idle();
    #1;
    n_checks++; if (b_rd_data !== {4{16'h1234}}) begin n_fail++; $display("FAIL param_new_data: got %h expected 1234123412341234", b_rd_data); end
    n_checks++; if (b_busy_vec !== 32'h0) begin n_fail++; $display("FAIL param_busy_clear: got %h expected 0", b_busy_vec); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom_range(0, 49) == 0);
      a_wr_en   = $urandom_range(0, 1) == 1;
      a_wr_addr = 4'($urandom_range(0, 15));
      a_wr_data = $urandom;
      a_sb_set  = $urandom_range(0, 2) == 0;
      a_sb_addr = ($urandom_range(0, 3) == 0) ? a_wr_addr : 4'($urandom_range(0, 15));
      for (int p = 0; p < 3; p++)
        a_rd_addr[p*4 +: 4] = ($urandom_range(0, 2) == 0) ? a_wr_addr : 4'($urandom_range(0, 15));
      b_wr_en   = $urandom_range(0, 1) == 1;
      b_wr_addr = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      b_wr_data = 16'($urandom);
      b_sb_set  = $urandom_range(0, 2) == 0;
      b_sb_addr = ($urandom_range(0, 3) == 0) ? b_wr_addr : 5'($urandom_range(0, 7));
      for (int p = 0; p < 4; p++)
        b_rd_addr[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? b_wr_addr : 5'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < 3; p++) begin
        n_checks++;
        if (a_rd_data[p*32 +: 32] !== a_exp_data(p)) begin
          n_fail++; $display("FAIL rand_a_data cyc %0d port %0d: got %h expected %h", cyc, p, a_rd_data[p*32 +: 32], a_exp_data(p));
        end
        n_checks++;
        if (a_rd_busy[p] !== a_exp_busy(p)) begin
          n_fail++; $display("FAIL rand_a_busy cyc %0d port %0d: got %b expected %b", cyc, p, a_rd_busy[p], a_exp_busy(p));
        end
      end
      n_checks++;
      if (a_busy_vec !== m_busy) begin
        n_fail++; $display("FAIL rand_a_busy_vec cyc %0d: got %h expected %h", cyc, a_busy_vec, m_busy);
      end
      for (int p = 0; p < 4; p++) begin
        n_checks++;
        if (b_rd_data[p*16 +: 16] !== b_exp_data(p)) begin
          n_fail++; $display("FAIL rand_b_data cyc %0d port %0d: got %h expected %h", cyc, p, b_rd_data[p*16 +: 16], b_exp_data(p));
        end
        n_checks++;
        if (b_rd_busy[p] !== b_exp_busy(p)) begin
          n_fail++; $display("FAIL rand_b_busy cyc %0d port %0d: got %b expected %b", cyc, p, b_rd_busy[p], b_exp_busy(p));
        end
      end
      n_checks++;
      if (b_busy_vec !== k_busy) begin
        n_fail++; $display("FAIL rand_b_busy_vec cyc %0d: got %h expected %h", cyc, b_busy_vec, k_busy);
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_bypass();
    test_r0();
    test_scoreboard();
    test_set_clear();
    test_param();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
